// File: rtl/aes_pkg.sv
// Shared AES datapath types and widths for the round controller blocks.
package aes_pkg;

  localparam int AES_COL_W   = 32;
  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ms_state_t;

endpackage

// File: rtl/mix_columns.sv
// Combinational single-column MixColumns, forward and inverse in parallel.
module mix_columns
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] mix_in,
  output logic [AES_COL_W-1:0] mix_out_enc,
  output logic [AES_COL_W-1:0] mix_out_dec
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = mix_in[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
  end

  // Inverse coefficients built from the doubling chain: 9=8+1, 11=8+2+1, 13=8+4+1, 14=8+4+2.
  always_comb begin
    mix_out_enc = '0;
    mix_out_dec = '0;
    for (int i = 0; i < 4; i++) begin
      mix_out_enc[31-8*i -: 8] = x2[i] ^ (x2[(i+1)%4] ^ a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      mix_out_dec[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                               ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                               ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                               ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns: one shared mix_columns instance, one column per cycle.
//
//  state | meaning
//  IDLE  | waiting for a state, in_ready high
//  RUN   | pushing column col_cnt through mix_columns
//  DONE  | result held on state_out until out_ready
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] state_in,
  input  logic                   enc_dec,
  input  logic                   bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] state_out,
  output logic                   busy
);

  ms_state_t              state;
  logic [1:0]             col_cnt;
  logic [AES_STATE_W-1:0] src;
  logic [AES_STATE_W-1:0] res;
  logic                   enc_q;
  logic                   byp_q;
  logic [AES_COL_W-1:0]   mix_in;
  logic [AES_COL_W-1:0]   mix_out_enc;
  logic [AES_COL_W-1:0]   mix_out_dec;
  logic [AES_COL_W-1:0]   col_out;

  always_comb begin
    mix_in = '0;
    case (col_cnt)
      2'd0:    mix_in = src[127:96];
      2'd1:    mix_in = src[95:64];
      2'd2:    mix_in = src[63:32];
      default: mix_in = src[31:0];
    endcase
  end

  mix_columns u_mix (
    .mix_in      (mix_in),
    .mix_out_enc (mix_out_enc),
    .mix_out_dec (mix_out_dec)
  );

  always_comb begin
    col_out = '0;
    if (byp_q)      col_out = mix_in;
    else if (enc_q) col_out = mix_out_enc;
    else            col_out = mix_out_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= 2'd0;
      src       <= '0;
      res       <= '0;
      enc_q     <= 1'b0;
      byp_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            src      <= state_in;
            enc_q    <= enc_dec;
            byp_q    <= bypass;
            col_cnt  <= 2'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (bypass) begin
              res       <= state_in;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          case (col_cnt)
            2'd0:    res[127:96] <= col_out;
            2'd1:    res[95:64]  <= col_out;
            2'd2:    res[63:32]  <= col_out;
            default: res[31:0]   <= col_out;
          endcase
          col_cnt <= col_cnt + 2'd1;
          if (col_cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = res;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq with a bit-serial GF(2^8) reference model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         enc_dec;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = 0;
  int prev_acc = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] G_PLAIN = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] G_MIXED = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] G_BYP   = 128'h00112233_44556677_8899aabb_ccddeeff;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .enc_dec   (enc_dec),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic enc);
    logic [7:0] ce [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] cd [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        logic [7:0] acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(s[127-32*c-8*j -: 8], enc ? ce[(j-i+4)%4] : cd[(j-i+4)%4]);
        r[127-32*c-8*i -: 8] = acc;
      end
    return r;
  endfunction

  // Result checker: an output is consumed whenever the handshake will complete at the next edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", state_out, 128'hx);
      else chk("result", state_out, sb.pop_front());
    end
  end

  task automatic send(input logic [127:0] d, input logic enc, input logic byp,
                      input logic [127:0] exp, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; state_in = d; enc_dec = enc; bypass = byp;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", {127'd0, in_ready}, 128'd1);
    if (push) sb.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prev_acc = last_acc;
    last_acc = cyc;
  endtask

  task automatic valid_latency(output int n);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
  endtask

  task automatic drain;
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("drain_timeout", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] held;
    logic [127:0] x, y;

    rst = 1'b1; in_valid = 1'b0; state_in = '0; enc_dec = 1'b0; bypass = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    rst = 1'b0;

    send(G_PLAIN, 1'b1, 1'b0, G_MIXED, 1'b1);
    valid_latency(lat);
    chk("fwd_latency", 128'(lat), 128'd4);
    drain();

    send(G_MIXED, 1'b0, 1'b0, G_PLAIN, 1'b1);
    drain();

    send(G_BYP, 1'b0, 1'b1, G_BYP, 1'b1);
    valid_latency(lat);
    chk("byp_latency", 128'(lat), 128'd0);
    send(G_PLAIN, 1'b1, 1'b1, G_PLAIN, 1'b1);
    chk("byp_spacing", 128'(last_acc - prev_acc), 128'd2);
    drain();

    // Backpressure: result must hold and new input must be refused.
    out_ready = 1'b0;
    send(G_PLAIN, 1'b1, 1'b0, G_MIXED, 1'b1);
    valid_latency(lat);
    held = state_out;
    chk("bp_held", held, G_MIXED);
    @(negedge clk);
    in_valid = 1'b1; state_in = G_BYP; enc_dec = 1'b0; bypass = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", state_out, held);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("bp_release_ready", {127'd0, in_ready}, 128'd1);
    chk("bp_release_valid", {127'd0, out_valid}, 128'd0);
    chk("bp_no_extra", 128'(sb.size()), 128'd0);

    // Reset asserted while columns are still being computed.
    send(G_PLAIN, 1'b1, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_state_out", state_out, 128'd0);
    send(G_PLAIN, 1'b1, 1'b0, G_MIXED, 1'b1);
    drain();

    // Back-to-back round trips with out_ready tied high.
    for (int i = 0; i < 5; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      y = model(x, 1'b1);
      send(x, 1'b1, 1'b0, y, 1'b1);
      if (i != 0) chk("b2b_spacing", 128'(last_acc - prev_acc), 128'd6);
      send(y, 1'b0, 1'b0, x, 1'b1);
      chk("b2b_spacing", 128'(last_acc - prev_acc), 128'd6);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
